// File: rtl/key_step_debounce.sv
// Push-button conditioner: synchronises and debounces an active-low key into a
// clean level plus one-cycle step strobes (with optional auto-repeat), and
// synchronises the direction switch onto the same clock.
module key_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key0,
  input  logic sw0,
  output logic key_level,
  output logic key_pulse,
  output logic sw0_sync
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  // Synchronisers. The key chain stores the inverted level so a cleared
  // chain reads as "not pressed".
  logic key_s1_q, key_s2_q;
  logic sw_s1_q,  sw_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= 1'b0;
      key_s2_q <= 1'b0;
      sw_s1_q  <= 1'b0;
      sw_s2_q  <= 1'b0;
    end else begin
      key_s1_q <= ~key0;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw0;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign sw0_sync = sw_s2_q;

  // Debounce: accept a new level only after it has disagreed with the
  // current one for DEBOUNCE_CYCLES consecutive cycles.
  logic          level_q, level_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (key_s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = key_s2_q;
        db_cnt_d = '0;
      end else if (db_cnt_q != CNT_SAT) begin
        db_cnt_d = db_cnt_q + CW'(1);
      end else begin
        db_cnt_d = db_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign key_level = level_q;

  // Pulse FSM looks at the next level so the press strobe lands on the same
  // edge as key_level, and a release on a repeat edge suppresses the strobe.
  state_t        state_q, state_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          pulse_q, pulse_d;
  logic          rise;
  logic [CW-1:0] rep_inc;

  assign rise    = level_d & ~level_q;
  assign rep_inc = (rep_cnt_q == CNT_SAT) ? rep_cnt_q : rep_cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    pulse_d   = 1'b0;
    rep_cnt_d = rep_inc;
    case (state_q)
      IDLE: begin
        rep_cnt_d = '0;
        if (rise) begin
          pulse_d = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!level_d) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if ((REPEAT_EN != 0) && (rep_cnt_q == RD_LAST)) begin
          pulse_d   = 1'b1;
          state_d   = REPEAT;
          rep_cnt_d = '0;
        end
      end
      REPEAT: begin
        if (!level_d) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RP_LAST) begin
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign key_pulse = pulse_q;

endmodule
